ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
- Parametrised, registered execute stage for the ARM-subset pipeline.
- Forwarding muxes on both Rn and Rm, Val2 generation, single-cycle ALU, branch-target adder.
- Iterative shift-add multiplier (MUL) that stalls upstream while busy.
- Drives its own EX/MEM output register, with a downstream hold and a flush.

Parameters:
- DATA_W, 32: datapath width; must be >=16 and even.
- MUL_BPC, 8: multiplier bits retired per cycle; must divide DATA_W. MUL occupancy is DATA_W/MUL_BPC cycles.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue slot holds a valid instruction.
- flush  in  1  kill in-flight and registered instruction.
- mem_stall  in  1  downstream cannot accept; hold output register.
- EXE_CMD  in  4  ALU operation.
- S  in  1  update status register.
- WB_EN, MEM_R_EN, MEM_W_EN  in  1 each  control, passed through.
- Dest  in  4  destination register, passed through.
- PC  in  DATA_W  PC+4 of instruction.
- Val_Rn, Val_Rm  in  DATA_W  register-file operands.
- forward1, forward2  in  2  00 = regfile, 01 = MEM value, 10 = WB value, 11 = regfile.
- MEM_fwd, WB_fwd  in  DATA_W  forwarding sources.
- Shift_operand  in  12  ARM shifter operand.
- imm  in  1  immediate form.
- Signed_imm_24  in  24  branch offset.
- busy  out  1  multiplier occupied; upstream must hold.
- out_valid  out  1  registered result valid.
- ALU_Result_q, Val_Rm_q, Branch_Address_q  out  DATA_W  registered.
- Dest_q  out  4  registered.
- WB_EN_q, MEM_R_EN_q, MEM_W_EN_q  out  1 each  registered.
- SR  out  4  status register {N,Z,C,V}.

Behaviour:
- Reset: all outputs and internal state 0; FSM in IDLE.
- Operand selection: Rn = forward1 mux, Rm = forward2 mux. Val_Rm_q captures the forwarded Rm.
- Val2, in priority order:
  - MEM_R_EN|MEM_W_EN: zero-extended Shift_operand[11:0].
  - imm: Shift_operand[7:0] rotated right by 2*Shift_operand[11:8].
  - Otherwise: Rm shifted by Shift_operand[11:7], type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). Amount 0 means no shift.
- EXE_CMD encoding:
  - 0001 MOV; 1001 MVN.
  - 0010 ADD; 0011 ADC (+C).
  - 0100 SUB; 0101 SBC (-!C).
  - 0110 AND; 0111 ORR; 1000 EOR.
  - 1010 MUL, result = low DATA_W bits of Rn*Rm.
  - Others: result 0, flags unaffected.
- Flags: N = result MSB; Z = result==0. C/V from ADD/ADC/SUB/SBC only; logic ops and MUL keep C, V. SR is written only when S=1 and the instruction completes (IDLE accept or MUL DONE), never on flush.
- Branch_Address_q = PC + (sign-extended Signed_imm_24 << 2), truncated to DATA_W.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, in_valid & !mem_stall & !flush, non-MUL: output register loads next edge. Latency 1 cycle.
  - IDLE, in_valid & MUL: latch operands and controls, counter = DATA_W/MUL_BPC, go MUL, busy=1 from next cycle. out_valid_q falls unless mem_stall holds it.
  - MUL: each cycle accumulate MUL_BPC multiplier bits. At counter 1, load output register and go IDLE, busy=0 same edge. If mem_stall is high at that edge, go HOLD instead.
  - HOLD: busy=1; load on first cycle with mem_stall=0, then go IDLE.
- mem_stall in IDLE: output register and SR unchanged; busy stays 0. Upstream must already see the pipeline-wide freeze, so in_valid is ignored.
- flush (any state): next edge out_valid=0, FSM to IDLE, busy=0, no SR write. Flush beats mem_stall.
- in_valid while busy: ignored.
- RST mid-MUL: immediate return to reset values.

Optional Feature:
- Macro EX_STAGE_MLA_EN.
- Defined: adds input Val_Ra [DATA_W]. EXE_CMD 1011 = MLA, result = Rn*Rm + Val_Ra, same latency and flag rules as MUL.
- Undefined: no Val_Ra port; 1011 behaves as any unused code.

Test Plan:
- ADD, Val_Rn=5, Rm=7, S=1 -> one cycle later ALU_Result_q=12, out_valid=1, SR=0000.
- SUB, Rn=3, imm=1, Shift_operand=12'h001, S=1 -> result 2, SR=0010 (C set, no borrow).
- MUL, Rn=0x10001, Rm=3, DATA_W=32, MUL_BPC=8 -> busy high 4 cycles, then result 0x30003.
  - A second in_valid during busy is ignored.
- forward1=01, MEM_fwd=100, Val_Rn=1, MOV with Rm forward2=10, WB_fwd=9 -> Rn path uses 100; result 9, Val_Rm_q=9.
- MUL with mem_stall asserted at completion -> FSM HOLD; result appears on the first cycle mem_stall=0.
- flush mid-MUL -> next cycle busy=0, out_valid=0, SR unchanged.
- Branch: PC=0x100, Signed_imm_24=24'hFFFFFE -> Branch_Address_q=0xF8.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Registered execute stage: operand forwarding, Val2 shifter, ALU, branch adder, iterative MUL.
// Define EX_STAGE_MLA_EN to add the Val_Ra port and the MLA command (EXE_CMD 1011).
module ex_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic [3:0]        EXE_CMD,
  input  logic              S,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [3:0]        Dest,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] Val_Rn,
  input  logic [DATA_W-1:0] Val_Rm,
  input  logic [1:0]        forward1,
  input  logic [1:0]        forward2,
  input  logic [DATA_W-1:0] MEM_fwd,
  input  logic [DATA_W-1:0] WB_fwd,
  input  logic [11:0]       Shift_operand,
  input  logic              imm,
  input  logic [23:0]       Signed_imm_24,
`ifdef EX_STAGE_MLA_EN
  input  logic [DATA_W-1:0] Val_Ra,
`endif
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALU_Result_q,
  output logic [DATA_W-1:0] Val_Rm_q,
  output logic [DATA_W-1:0] Branch_Address_q,
  output logic [3:0]        Dest_q,
  output logic              WB_EN_q,
  output logic              MEM_R_EN_q,
  output logic              MEM_W_EN_q,
  output logic [3:0]        SR
);

  localparam int STEPS = DATA_W / MUL_BPC;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int M     = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, nstate;

  logic [DATA_W-1:0] rn, rm, val2, res, opb, br;
  logic [DATA_W:0]   sum;
  logic              cin, sub, arith, fl_upd, is_mul, ovf;
  logic [3:0]        flags;

  logic [DATA_W-1:0] acc, acc_nxt, part, mcand, mplier, mul_res;
  logic [CW-1:0]     cnt;
  logic              p_s, p_wb, p_mr, p_mw;
  logic [3:0]        p_dest;
  logic [DATA_W-1:0] p_rm, p_br;
  logic              start, step, ld_alu, ld_mul, bubble;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                            input int n);
    int k;
    k = n % DATA_W;
    return (x >> k) | (x << (DATA_W - k));
  endfunction

  always_comb begin
    unique case (forward1)
      2'b01:   rn = MEM_fwd;
      2'b10:   rn = WB_fwd;
      default: rn = Val_Rn;
    endcase
    unique case (forward2)
      2'b01:   rm = MEM_fwd;
      2'b10:   rm = WB_fwd;
      default: rm = Val_Rm;
    endcase
  end

  always_comb begin
    val2 = rm;
    if (MEM_R_EN | MEM_W_EN)
      val2 = DATA_W'(Shift_operand);
    else if (imm)
      val2 = ror(DATA_W'(Shift_operand[7:0]), 2 * int'(Shift_operand[11:8]));
    else if (Shift_operand[11:7] != 5'd0) begin
      unique case (Shift_operand[6:5])
        2'b00:   val2 = rm << Shift_operand[11:7];
        2'b01:   val2 = rm >> Shift_operand[11:7];
        2'b10:   val2 = $signed(rm) >>> Shift_operand[11:7];
        default: val2 = ror(rm, int'(Shift_operand[11:7]));
      endcase
    end
  end

  // One adder serves ADD/ADC/SUB/SBC; subtraction is rn + ~val2 + carry.
  always_comb begin
    res    = '0;
    fl_upd = 1'b1;
    arith  = 1'b0;
    sub    = 1'b0;
    cin    = 1'b0;
    case (EXE_CMD)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = SR[1]; end
      4'b0100: begin arith = 1'b1; sub = 1'b1; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; sub = 1'b1; cin = SR[1]; end
      4'b0110: res = rn & val2;
      4'b0111: res = rn | val2;
      4'b1000: res = rn ^ val2;
      default: fl_upd = 1'b0;
    endcase
    opb = sub ? ~val2 : val2;
    sum = {1'b0, rn} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
    ovf = (rn[M] == opb[M]) && (sum[M] != rn[M]);
    if (arith) res = sum[DATA_W-1:0];
    flags = {res[M], res == '0,
             arith ? sum[DATA_W] : SR[1],
             arith ? ovf : SR[0]};
  end

`ifdef EX_STAGE_MLA_EN
  assign is_mul = (EXE_CMD == 4'b1010) || (EXE_CMD == 4'b1011);
`else
  assign is_mul = (EXE_CMD == 4'b1010);
`endif

  assign br = PC + DATA_W'($signed({Signed_imm_24, 2'b00}));

  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_BPC; i++)
      if (mplier[i]) part = part + (mcand << i);
  end

  assign acc_nxt = acc + part;
  assign mul_res = (state == MUL) ? acc_nxt : acc;
  assign busy    = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    start  = 1'b0;
    step   = 1'b0;
    ld_alu = 1'b0;
    ld_mul = 1'b0;
    bubble = 1'b0;
    if (flush)
      nstate = IDLE;
    else begin
      unique case (state)
        IDLE: if (!mem_stall) begin
          if (in_valid && is_mul) begin
            start  = 1'b1;
            nstate = MUL;
          end else if (in_valid) ld_alu = 1'b1;
          else bubble = 1'b1;
        end
        MUL: begin
          step = 1'b1;
          if (cnt == CW'(1)) begin
            if (mem_stall) nstate = HOLD;
            else begin
              ld_mul = 1'b1;
              nstate = IDLE;
            end
          end
        end
        default: if (!mem_stall) begin
          ld_mul = 1'b1;
          nstate = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid        <= 1'b0;
      ALU_Result_q     <= '0;
      Val_Rm_q         <= '0;
      Branch_Address_q <= '0;
      Dest_q           <= '0;
      WB_EN_q          <= 1'b0;
      MEM_R_EN_q       <= 1'b0;
      MEM_W_EN_q       <= 1'b0;
      SR               <= '0;
      acc              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      cnt              <= '0;
      p_s              <= 1'b0;
      p_wb             <= 1'b0;
      p_mr             <= 1'b0;
      p_mw             <= 1'b0;
      p_dest           <= '0;
      p_rm             <= '0;
      p_br             <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (ld_alu) begin
        out_valid        <= 1'b1;
        ALU_Result_q     <= res;
        Val_Rm_q         <= rm;
        Branch_Address_q <= br;
        Dest_q           <= Dest;
        WB_EN_q          <= WB_EN;
        MEM_R_EN_q       <= MEM_R_EN;
        MEM_W_EN_q       <= MEM_W_EN;
        if (S && fl_upd) SR <= flags;
      end else if (ld_mul) begin
        out_valid        <= 1'b1;
        ALU_Result_q     <= mul_res;
        Val_Rm_q         <= p_rm;
        Branch_Address_q <= p_br;
        Dest_q           <= p_dest;
        WB_EN_q          <= p_wb;
        MEM_R_EN_q       <= p_mr;
        MEM_W_EN_q       <= p_mw;
        if (p_s) SR <= {mul_res[M], mul_res == '0, SR[1:0]};
      end else if (start || bubble)
        out_valid <= 1'b0;

      if (start) begin
`ifdef EX_STAGE_MLA_EN
        acc <= (EXE_CMD == 4'b1011) ? Val_Ra : '0;
`else
        acc <= '0;
`endif
        mcand  <= rn;
        mplier <= rm;
        cnt    <= CW'(STEPS);
        p_s    <= S;
        p_wb   <= WB_EN;
        p_mr   <= MEM_R_EN;
        p_mw   <= MEM_W_EN;
        p_dest <= Dest;
        p_rm   <= rm;
        p_br   <= br;
      end else if (step) begin
        acc    <= acc_nxt;
        mcand  <= mcand << MUL_BPC;
        mplier <= mplier >> MUL_BPC;
        cnt    <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: ALU table, forwarding, MUL busy/hold/flush, branch, reset.
module tb_ex_stage_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 0, flush = 0, mem_stall = 0;
  logic [3:0]  EXE_CMD = 0;
  logic        S = 0, WB_EN = 0, MEM_R_EN = 0, MEM_W_EN = 0;
  logic [3:0]  Dest = 0;
  logic [31:0] PC = 0, Val_Rn = 0, Val_Rm = 0, MEM_fwd = 0, WB_fwd = 0;
  logic [1:0]  forward1 = 0, forward2 = 0;
  logic [11:0] Shift_operand = 0;
  logic        imm = 0;
  logic [23:0] Signed_imm_24 = 0;
`ifdef EX_STAGE_MLA_EN
  logic [31:0] Val_Ra = 0;
`endif
  logic        busy, out_valid;
  logic [31:0] ALU_Result_q, Val_Rm_q, Branch_Address_q;
  logic [3:0]  Dest_q, SR;
  logic        WB_EN_q, MEM_R_EN_q, MEM_W_EN_q;

  ex_stage_mc #(.DATA_W(32), .MUL_BPC(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .flush(flush),
    .mem_stall(mem_stall), .EXE_CMD(EXE_CMD), .S(S), .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .Dest(Dest), .PC(PC),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .forward1(forward1),
    .forward2(forward2), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd),
    .Shift_operand(Shift_operand), .imm(imm),
    .Signed_imm_24(Signed_imm_24),
`ifdef EX_STAGE_MLA_EN
    .Val_Ra(Val_Ra),
`endif
    .busy(busy), .out_valid(out_valid), .ALU_Result_q(ALU_Result_q),
    .Val_Rm_q(Val_Rm_q), .Branch_Address_q(Branch_Address_q),
    .Dest_q(Dest_q), .WB_EN_q(WB_EN_q), .MEM_R_EN_q(MEM_R_EN_q),
    .MEM_W_EN_q(MEM_W_EN_q), .SR(SR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  sr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [3:0]  cmd;
    logic        s, im, mr;
    logic [31:0] rn, rm;
    logic [11:0] sh;
    logic [31:0] res;
    logic [3:0]  sr;
  } vec_t;

  vec_t tbl [17] = '{
    '{4'h2, 1'b1, 1'b0, 1'b0, 32'd5,        32'd7,   12'h000, 32'd12,       4'b0000},
    '{4'h4, 1'b1, 1'b1, 1'b0, 32'd3,        32'd0,   12'h001, 32'd2,        4'b0010},
    '{4'h1, 1'b1, 1'b1, 1'b0, 32'd0,        32'd0,   12'h1FF, 32'hC000003F, 4'b1010},
    '{4'h1, 1'b0, 1'b0, 1'b0, 32'd0,        32'd1,   12'h200, 32'd16,       4'b1010},
    '{4'h1, 1'b1, 1'b0, 1'b0, 32'd0,   32'h80000000, 12'h240, 32'hF8000000, 4'b1010},
    '{4'h1, 1'b1, 1'b0, 1'b0, 32'd0,        32'hF,   12'h260, 32'hF0000000, 4'b1010},
    '{4'h4, 1'b1, 1'b0, 1'b0, 32'd5,        32'd5,   12'h000, 32'd0,        4'b0110},
    '{4'h2, 1'b1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1,   12'h000, 32'h80000000, 4'b1001},
    '{4'h3, 1'b1, 1'b0, 1'b0, 32'd1,        32'd1,   12'h000, 32'd2,        4'b0000},
    '{4'h4, 1'b1, 1'b0, 1'b0, 32'd1,        32'd2,   12'h000, 32'hFFFFFFFF, 4'b1000},
    '{4'h5, 1'b1, 1'b0, 1'b0, 32'd5,        32'd3,   12'h000, 32'd1,        4'b0010},
    '{4'h9, 1'b1, 1'b0, 1'b0, 32'd0,        32'd0,   12'h000, 32'hFFFFFFFF, 4'b1010},
    '{4'h6, 1'b1, 1'b0, 1'b0, 32'hF0F0,     32'hFF00,12'h000, 32'hF000,     4'b0010},
    '{4'h7, 1'b1, 1'b0, 1'b0, 32'hF0,       32'h0F,  12'h000, 32'hFF,       4'b0010},
    '{4'h8, 1'b1, 1'b0, 1'b0, 32'hFF,       32'hFF,  12'h000, 32'h0,        4'b0110},
    '{4'hF, 1'b1, 1'b0, 1'b0, 32'd3,        32'd4,   12'h000, 32'h0,        4'b0110},
    '{4'h2, 1'b0, 1'b0, 1'b1, 32'h1000,     32'd0,   12'hABC, 32'h1ABC,     4'b0110}
  };

  task automatic set_op(input logic [3:0] cmd, input logic s,
                        input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] sh, input logic im,
                        input logic mr);
    EXE_CMD = cmd; S = s; Val_Rn = rn; Val_Rm = rm;
    Shift_operand = sh; imm = im; MEM_R_EN = mr; in_valid = 1'b1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic s,
                       input logic [31:0] rn, input logic [31:0] rm,
                       input logic [11:0] sh, input logic im,
                       input logic mr);
    set_op(cmd, s, rn, rm, sh, im, mr);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({out_valid, busy, SR} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b required 000000", {out_valid, busy, SR});
    end
    n_cmp++;
    if (ALU_Result_q !== 32'h0) begin
      n_err++;
      $display("FAIL reset_res: got %h required 0", ALU_Result_q);
    end
    RST = 1'b0;
  endtask

  task automatic test_alu;
    bit ok;
    exp_t e;
    for (int i = 0; i < 17; i++) begin
      issue(tbl[i].cmd, tbl[i].s, tbl[i].rn, tbl[i].rm, tbl[i].sh,
            tbl[i].im, tbl[i].mr);
      exp_q.push_back('{res: tbl[i].res, sr: tbl[i].sr});
      wait_out(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || {ALU_Result_q, SR} !== {e.res, e.sr}) begin
        n_err++;
        $display("FAIL alu[%0d]: got %h/%b required %h/%b ok=%0d",
                 i, ALU_Result_q, SR, e.res, e.sr, ok);
      end
    end
    n_cmp++;
    if (MEM_R_EN_q !== 1'b1) begin
      n_err++;
      $display("FAIL mem_r_pass: got %b required 1", MEM_R_EN_q);
    end
    MEM_R_EN = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [3] = '{32'd1, 32'd10, 32'h100};
    logic [31:0] b [3] = '{32'd2, 32'd20, 32'h200};
    exp_t e;
    @(negedge CLK);
    set_op(4'h2, 1'b0, a[0], b[0], 12'h0, 1'b0, 1'b0);
    exp_q.push_back('{res: a[0] + b[0], sr: 4'b0110});
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (i < 2) begin
        set_op(4'h2, 1'b0, a[i+1], b[i+1], 12'h0, 1'b0, 1'b0);
        exp_q.push_back('{res: a[i+1] + b[i+1], sr: 4'b0110});
      end else in_valid = 1'b0;
      @(negedge CLK);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, ALU_Result_q, SR} !== {1'b1, e.res, e.sr}) begin
        n_err++;
        $display("FAIL b2b[%0d]: got v=%b %h/%b required %h/%b",
                 i, out_valid, ALU_Result_q, SR, e.res, e.sr);
      end
    end
  endtask

  task automatic test_forward;
    bit ok;
    forward1 = 2'b01; MEM_fwd = 32'd100; forward2 = 2'b10; WB_fwd = 32'd9;
    issue(4'h1, 1'b0, 32'd1, 32'd5, 12'h0, 1'b0, 1'b0);
    wait_out(ok);
    n_cmp++;
    if (!ok || {ALU_Result_q, Val_Rm_q} !== {32'd9, 32'd9}) begin
      n_err++;
      $display("FAIL fwd_mov: got %h/%h required 9/9", ALU_Result_q, Val_Rm_q);
    end
    issue(4'h2, 1'b0, 32'd1, 32'd5, 12'h0, 1'b0, 1'b0);
    wait_out(ok);
    n_cmp++;
    if (!ok || ALU_Result_q !== 32'd109) begin
      n_err++;
      $display("FAIL fwd_add: got %0d required 109", ALU_Result_q);
    end
    forward1 = 2'b00; forward2 = 2'b00;
  endtask

  task automatic test_mul;
    int nb = 0;
    bit ok = 1'b0;
    exp_t e;
    issue(4'hA, 1'b1, 32'h10001, 32'd3, 12'h0, 1'b0, 1'b0);
    exp_q.push_back('{res: 32'h10001 * 32'd3, sr: 4'b0010});
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) begin ok = 1'b1; break; end
      if (busy) nb++;
      if (i == 0) set_op(4'h2, 1'b1, 32'd7, 32'd7, 12'h0, 1'b0, 1'b0);
      if (i == 2) in_valid = 1'b0;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || {ALU_Result_q, SR} !== {e.res, e.sr}) begin
      n_err++;
      $display("FAIL mul_res: got %h/%b required %h/%b", ALU_Result_q, SR, e.res, e.sr);
    end
    n_cmp++;
    if (nb !== 4 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mul_busy: got %0d cycles busy_end=%b required 4/0", nb, busy);
    end
    @(negedge CLK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mul_ignore: got out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_mul_hold;
    int bad = 0;
    bit ok;
    exp_t e;
    issue(4'hA, 1'b0, 32'h1234, 32'h10, 12'h0, 1'b0, 1'b0);
    exp_q.push_back('{res: 32'h12340, sr: 4'b0010});
    repeat (2) @(negedge CLK);
    mem_stall = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_wait: got %0d bad cycles required 0", bad);
    end
    mem_stall = 1'b0;
    wait_out(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || {ALU_Result_q, SR, busy} !== {e.res, e.sr, 1'b0}) begin
      n_err++;
      $display("FAIL hold_res: got %h/%b busy=%b required %h/%b busy=0",
               ALU_Result_q, SR, busy, e.res, e.sr);
    end
  endtask

  task automatic test_flush;
    int bad = 0;
    issue(4'hA, 1'b1, 32'h80000000, 32'd1, 12'h0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({busy, out_valid, SR} !== 6'b00_0010) begin
      n_err++;
      $display("FAIL flush_now: got %b required 000010", {busy, out_valid, SR});
    end
    repeat (6) begin
      @(negedge CLK);
      if (out_valid !== 1'b0 || SR !== 4'b0010) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL flush_late: got %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_stall_idle;
    bit ok;
    issue(4'h2, 1'b1, 32'd4, 32'd4, 12'h0, 1'b0, 1'b0);
    wait_out(ok);
    n_cmp++;
    if (!ok || {ALU_Result_q, SR} !== {32'd8, 4'b0000}) begin
      n_err++;
      $display("FAIL stall_pre: got %h/%b required 8/0000", ALU_Result_q, SR);
    end
    mem_stall = 1'b1;
    set_op(4'h2, 1'b1, 32'd1, 32'd1, 12'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({out_valid, busy, ALU_Result_q, SR} !== {2'b10, 32'd8, 4'b0000}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b b=%b %h/%b required 1/0 8/0000",
                 i, out_valid, busy, ALU_Result_q, SR);
      end
    end
    flush = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({out_valid, SR} !== 5'b0_0000) begin
      n_err++;
      $display("FAIL flush_over_stall: got %b required 00000", {out_valid, SR});
    end
    flush = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic test_branch;
    bit ok;
    PC = 32'h100; Signed_imm_24 = 24'hFFFFFE; Dest = 4'hA; WB_EN = 1'b1;
    issue(4'h1, 1'b0, 32'd0, 32'd3, 12'h0, 1'b0, 1'b0);
    wait_out(ok);
    n_cmp++;
    if (!ok || {Branch_Address_q, Dest_q, WB_EN_q} !== {32'hF8, 4'hA, 1'b1}) begin
      n_err++;
      $display("FAIL br_neg: got %h/%h/%b required f8/a/1",
               Branch_Address_q, Dest_q, WB_EN_q);
    end
    PC = 32'h1000; Signed_imm_24 = 24'h000010; WB_EN = 1'b0;
    issue(4'h1, 1'b0, 32'd0, 32'd3, 12'h0, 1'b0, 1'b0);
    wait_out(ok);
    n_cmp++;
    if (!ok || {Branch_Address_q, WB_EN_q} !== {32'h1040, 1'b0}) begin
      n_err++;
      $display("FAIL br_pos: got %h/%b required 1040/0", Branch_Address_q, WB_EN_q);
    end
  endtask

  task automatic test_reset_mid_mul;
    issue(4'hA, 1'b1, 32'd6, 32'd7, 12'h0, 1'b0, 1'b0);
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_busy: got %b required 1", busy);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({busy, out_valid, SR, ALU_Result_q} !== 38'h0) begin
      n_err++;
      $display("FAIL rst_mid_mul: got b=%b v=%b sr=%b res=%h required all 0",
               busy, out_valid, SR, ALU_Result_q);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_forward();
    test_mul();
    test_mul_hold();
    test_flush();
    test_stall_idle();
    test_branch();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
